dct_transpose_buf: RTL and testbench

Ping-pong 8×8 transpose buffer for the 2-D DCT path. It sits directly downstream of the row-wise 1-D DCT (8 coefficients per handshake) and upstream of the column-wise 1-D DCT. It accepts eight rows of a block and presents that block back as eight columns, using the same 8-lane valid/ready interface on both sides. Two banks let block N+1 be written while block N drains, so throughput is one row or column per clock.

---
 rtl/dct_pkg.sv | 8 +
 rtl/transpose_bank.sv | 32 +++
 rtl/dct_transpose_buf.sv | 123 ++++++++++++
 tb/tb_dct_transpose_buf.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared constants and index types for the 2-D DCT datapath (row stage, transpose, column stage).
package dct_pkg;
   localparam int N            = 8;
   localparam int IN_W_DEFAULT = 32;

   typedef logic [2:0] idx_t;
   typedef logic       bank_sel_t;
endpackage

// File: rtl/transpose_bank.sv
// One 8x8 storage bank: whole-row write port, combinational whole-column read port.
// Contents are deliberately unreset; the owning controller's full flag says when they are meaningful.
module transpose_bank
   import dct_pkg::*;
#(
   parameter int W = IN_W_DEFAULT
) (
   input  logic               clk,
   input  logic               we_i,
   input  idx_t               row_i,
   input  logic [N-1:0][W-1:0] row_dat_i,
   input  idx_t               col_i,
   output logic [N-1:0][W-1:0] col_dat_o
);

   // Indexed [row][col]; a column read gathers element col_i from every row.
   logic [N-1:0][N-1:0][W-1:0] mem_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[row_i] <= row_dat_i;
      end
   end

   always_comb begin
      col_dat_o = '0;
      for (int k = 0; k < N; k++) begin
         col_dat_o[k] = mem_q[k][col_i];
      end
   end

endmodule

// File: rtl/dct_transpose_buf.sv
// Ping-pong 8x8 transpose: rows in, columns out; column 0 valid 1 clk after row 7 accepted.
// Backpressure: in_ready/out_valid come from the bank full flags only; up to 16 rows absorbed while stalled.
module dct_transpose_buf
   import dct_pkg::*;
#(
   parameter int IN_W = IN_W_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic signed [IN_W-1:0] in0,
   input  logic signed [IN_W-1:0] in1,
   input  logic signed [IN_W-1:0] in2,
   input  logic signed [IN_W-1:0] in3,
   input  logic signed [IN_W-1:0] in4,
   input  logic signed [IN_W-1:0] in5,
   input  logic signed [IN_W-1:0] in6,
   input  logic signed [IN_W-1:0] in7,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic signed [IN_W-1:0] out0,
   output logic signed [IN_W-1:0] out1,
   output logic signed [IN_W-1:0] out2,
   output logic signed [IN_W-1:0] out3,
   output logic signed [IN_W-1:0] out4,
   output logic signed [IN_W-1:0] out5,
   output logic signed [IN_W-1:0] out6,
   output logic signed [IN_W-1:0] out7
);

   logic [1:0] full_q, full_d;
   bank_sel_t  wr_bank_q, wr_bank_d;
   bank_sel_t  rd_bank_q, rd_bank_d;
   idx_t       wr_row_q, wr_row_d;
   idx_t       rd_col_q, rd_col_d;
   logic       wr_fire, rd_fire;

   logic [N-1:0][IN_W-1:0] row_dat;
   logic [N-1:0][IN_W-1:0] col_dat0, col_dat1, out_dat;

   assign in_ready  = !full_q[wr_bank_q];
   assign out_valid = full_q[rd_bank_q];
   assign wr_fire   = in_valid && in_ready;
   assign rd_fire   = out_valid && out_ready;

   assign row_dat = {in7, in6, in5, in4, in3, in2, in1, in0};

   // Writer only sets a non-full bank and reader only clears a full one,
   // so the two updates below never collide on the same flag.
   always_comb begin
      full_d    = full_q;
      wr_bank_d = wr_bank_q;
      wr_row_d  = wr_row_q;
      rd_bank_d = rd_bank_q;
      rd_col_d  = rd_col_q;
      if (wr_fire) begin
         if (wr_row_q == idx_t'(N - 1)) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
            wr_row_d          = '0;
         end else begin
            wr_row_d = wr_row_q + 3'd1;
         end
      end
      if (rd_fire) begin
         if (rd_col_q == idx_t'(N - 1)) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
            rd_col_d          = '0;
         end else begin
            rd_col_d = rd_col_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q    <= '0;
         wr_bank_q <= 1'b0;
         wr_row_q  <= '0;
         rd_bank_q <= 1'b0;
         rd_col_q  <= '0;
      end else begin
         full_q    <= full_d;
         wr_bank_q <= wr_bank_d;
         wr_row_q  <= wr_row_d;
         rd_bank_q <= rd_bank_d;
         rd_col_q  <= rd_col_d;
      end
   end

   transpose_bank #(.W(IN_W)) u_bank0 (
      .clk       (clk),
      .we_i      (wr_fire && (wr_bank_q == 1'b0)),
      .row_i     (wr_row_q),
      .row_dat_i (row_dat),
      .col_i     (rd_col_q),
      .col_dat_o (col_dat0)
   );

   transpose_bank #(.W(IN_W)) u_bank1 (
      .clk       (clk),
      .we_i      (wr_fire && (wr_bank_q == 1'b1)),
      .row_i     (wr_row_q),
      .row_dat_i (row_dat),
      .col_i     (rd_col_q),
      .col_dat_o (col_dat1)
   );

   // Gating keeps unreset bank contents off the outputs while nothing is valid.
   assign out_dat = !out_valid ? '0 : (rd_bank_q ? col_dat1 : col_dat0);

   assign out0 = out_dat[0];
   assign out1 = out_dat[1];
   assign out2 = out_dat[2];
   assign out3 = out_dat[3];
   assign out4 = out_dat[4];
   assign out5 = out_dat[5];
   assign out6 = out_dat[6];
   assign out7 = out_dat[7];

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Self-checking bench for dct_transpose_buf: directed and random row streams against a block/column queue model.
module tb_dct_transpose_buf;
   localparam int W  = 32;
   localparam int NL = 8;
   typedef logic [NL-1:0][W-1:0] row_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic in_valid = 1'b0;
   logic in_ready;
   logic out_valid;
   logic out_ready = 1'b0;
   row_t in_row = '0;
   row_t obs_col;
   logic signed [W-1:0] in0, in1, in2, in3, in4, in5, in6, in7;
   logic signed [W-1:0] out0, out1, out2, out3, out4, out5, out6, out7;

   assign in0 = in_row[0];
   assign in1 = in_row[1];
   assign in2 = in_row[2];
   assign in3 = in_row[3];
   assign in4 = in_row[4];
   assign in5 = in_row[5];
   assign in6 = in_row[6];
   assign in7 = in_row[7];
   assign obs_col = {out7, out6, out5, out4, out3, out2, out1, out0};

   always #5 clk = ~clk;

   dct_transpose_buf #(.IN_W(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in0(in0), .in1(in1), .in2(in2), .in3(in3),
      .in4(in4), .in5(in5), .in6(in6), .in7(in7),
      .out_valid(out_valid), .out_ready(out_ready),
      .out0(out0), .out1(out1), .out2(out2), .out3(out3),
      .out4(out4), .out5(out5), .out6(out6), .out7(out7)
   );

   int   checks = 0;
   int   errors = 0;
   row_t src_q[$];   // rows waiting to be offered
   row_t part[$];    // rows of the block currently being assembled
   row_t exp_q[$];   // columns expected at the output, oldest first
   int   wr_acc = 0;
   int   rd_acc = 0;
   int   in_drops = 0;
   logic prev_stall = 1'b0;
   row_t prev_col = '0;

   task automatic chk(input string tag, input row_t obs, input row_t exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Two complete blocks occupy both banks; only then is the writer blocked.
   function automatic logic exp_in_ready();
      return ((exp_q.size() + NL - 1) / NL) < 2;
   endfunction

   task automatic push_block(input int base);
      row_t r;
      for (int i = 0; i < NL; i++) begin
         for (int c = 0; c < NL; c++) r[c] = W'(base + NL * i + c);
         src_q.push_back(r);
      end
   endtask

   task automatic push_rand_block();
      row_t r;
      for (int i = 0; i < NL; i++) begin
         for (int c = 0; c < NL; c++) r[c] = $urandom();
         src_q.push_back(r);
      end
   endtask

   // Called just after a rising edge; checks at the falling edge, updates the model after the next rise.
   task automatic cycle(input logic iv, input logic ordy);
      row_t ec, col;
      logic wf, rf;
      in_valid  = iv && (src_q.size() > 0);
      in_row    = (src_q.size() > 0) ? src_q[0] : '0;
      out_ready = ordy;
      @(negedge clk);
      chk("in_ready", row_t'(in_ready), row_t'(exp_in_ready()));
      chk("out_valid", row_t'(out_valid), row_t'(exp_q.size() > 0));
      ec = (exp_q.size() > 0) ? exp_q[0] : '0;
      chk("col_data", obs_col, ec);
      if (prev_stall) chk("stall_hold", obs_col, prev_col);
      if (in_valid && !in_ready) in_drops++;
      wf = in_valid && in_ready;
      rf = out_valid && out_ready;
      prev_stall = out_valid && !out_ready;
      prev_col   = obs_col;
      @(posedge clk);
      #1;
      if (wf) begin
         part.push_back(src_q.pop_front());
         wr_acc++;
         if (part.size() == NL) begin
            for (int c = 0; c < NL; c++) begin
               for (int k = 0; k < NL; k++) col[k] = part[k][c];
               exp_q.push_back(col);
            end
            part.delete();
         end
      end
      if (rf) begin
         void'(exp_q.pop_front());
         rd_acc++;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("rst_in_ready", row_t'(in_ready), row_t'(1));
      chk("rst_out_valid", row_t'(out_valid), row_t'(0));
      chk("rst_outs", obs_col, '0);
      src_q.delete();
      part.delete();
      exp_q.delete();
      prev_stall = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int w0, r0;
      row_t r;
      logic [W-1:0] ext [3];
      ext[0] = 32'h8000_0000;
      ext[1] = 32'h7fff_ffff;
      ext[2] = 32'hffff_ffff;

      #2;
      do_reset();

      // Single block, values 8r+c, consumer always ready.
      w0 = wr_acc; r0 = rd_acc;
      push_block(0);
      for (int i = 0; i < 24; i++) cycle(1'b1, 1'b1);
      chk("single_handshakes", row_t'(rd_acc - r0), row_t'(8));
      chk("single_rows", row_t'(wr_acc - w0), row_t'(8));

      // Four blocks streamed back to back.
      for (int b = 0; b < 4; b++) push_block(100 * b);
      w0 = wr_acc; r0 = rd_acc; in_drops = 0;
      for (int i = 0; i < 32; i++) cycle(1'b1, 1'b1);
      chk("stream_rows", row_t'(wr_acc - w0), row_t'(32));
      chk("stream_no_drop", row_t'(in_drops), row_t'(0));
      for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1);
      chk("stream_cols", row_t'(rd_acc - r0), row_t'(32));

      // Backpressure: 17 rows offered against a stalled consumer.
      push_block(1000); push_block(2000); push_block(3000);
      w0 = wr_acc; r0 = rd_acc;
      for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0);
      chk("bp_accepted", row_t'(wr_acc - w0), row_t'(16));
      chk("bp_in_ready_low", row_t'(in_ready), row_t'(0));
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1);
      chk("bp_drained_blk0", row_t'(rd_acc - r0), row_t'(8));
      chk("bp_17th_held", row_t'(wr_acc - w0), row_t'(16));
      cycle(1'b1, 1'b1);
      chk("bp_17th_taken", row_t'(wr_acc - w0), row_t'(17));
      for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1);
      chk("bp_all_out", row_t'(exp_q.size() + src_q.size()), row_t'(0));

      // Random valid/ready over 20 blocks.
      for (int b = 0; b < 20; b++) push_rand_block();
      r0 = rd_acc;
      for (int i = 0; i < 4000 && (src_q.size() > 0 || exp_q.size() > 0); i++)
         cycle(1'($urandom_range(1)), 1'($urandom_range(1)));
      chk("rand_drained", row_t'(exp_q.size() + src_q.size()), row_t'(0));
      chk("rand_cols", row_t'(rd_acc - r0), row_t'(160));

      // Extreme values.
      for (int i = 0; i < NL; i++) begin
         for (int c = 0; c < NL; c++) r[c] = ext[(i * NL + c) % 3];
         src_q.push_back(r);
      end
      for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1);
      chk("ext_drained", row_t'(exp_q.size() + src_q.size()), row_t'(0));

      // Reset with one block mid-drain and another half written.
      push_block(500); push_block(600);
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
      for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0);
      chk("pre_rst_part", row_t'(part.size()), row_t'(5));
      do_reset();
      push_block(700);
      r0 = rd_acc;
      for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1);
      chk("post_rst_cols", row_t'(rd_acc - r0), row_t'(8));
      chk("post_rst_drained", row_t'(exp_q.size()), row_t'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
